qpu_itcm_bankram: RTL and testbench

QPU_ITCM_BANKRAM -- requirements
Module: qpu_itcm_bankram

---
 rtl/qpu_itcm_bankram_pkg.sv | 13 +
 rtl/qpu_itcm_bank.sv | 34 +++
 rtl/qpu_itcm_bankram.sv | 145 ++++++++++++++
 tb/tb_qpu_itcm_bankram.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_itcm_bankram_pkg.sv
// Shared QPU defines: port identifiers and default ITCM geometry.
package qpu_itcm_bankram_pkg;

    typedef enum logic {
        PORT_IFU = 1'b0,
        PORT_LSU = 1'b1
    } port_id_e;

    localparam int DEF_DW    = 64;
    localparam int DEF_AW    = 16;
    localparam int DEF_NBANK = 2;

endpackage

// File: rtl/qpu_itcm_bank.sv
// Single-port byte-masked SRAM bank model with one-cycle read latency.
module qpu_itcm_bank #(
    parameter int DW    = 64,
    parameter int MW    = DW / 8,
    parameter int DEPTH = 1024,
    parameter int RW    = 10
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [MW-1:0] wem,
    input  logic [RW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    // Read port keeps its last value on writes and idle cycles.
    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) begin
                for (int i = 0; i < MW; i++) begin
                    if (wem[i]) begin
                        mem[addr][i*8 +: 8] <= din[i*8 +: 8];
                    end
                end
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/qpu_itcm_bankram.sv
// Banked ITCM with a read-only fetch port and a load/store port,
// round-robin arbitration on bank conflicts and light-sleep gating.
module qpu_itcm_bankram
    import qpu_itcm_bankram_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int MW    = DW / 8,
    parameter int AW    = DEF_AW,
    parameter int NBANK = DEF_NBANK,
    parameter int BDP   = 2 ** (AW - $clog2(NBANK))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_valid,
    output logic          ifu_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_rsp_valid,
    output logic [DW-1:0] ifu_rsp_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic          lsu_we,
    input  logic [AW-1:0] lsu_addr,
    input  logic [MW-1:0] lsu_wem,
    input  logic [DW-1:0] lsu_din,
    output logic          lsu_rsp_valid,
    output logic [DW-1:0] lsu_rsp_data,
    input  logic          ls
);

    localparam int LB = $clog2(NBANK);
    localparam int BW = (LB > 0) ? LB : 1;
    localparam int RW = AW - LB;

    logic [BW-1:0] ifu_bank;
    logic [BW-1:0] lsu_bank;
    logic [RW-1:0] ifu_row;
    logic [RW-1:0] lsu_row;

    generate
        if (LB == 0) begin : g_one
            assign ifu_bank = '0;
            assign lsu_bank = '0;
        end else begin : g_multi
            assign ifu_bank = ifu_addr[LB-1:0];
            assign lsu_bank = lsu_addr[LB-1:0];
        end
    endgenerate

    assign ifu_row = ifu_addr[AW-1:LB];
    assign lsu_row = lsu_addr[AW-1:LB];

    logic     up;
    logic     rdy_en;
    logic     conflict;
    logic     ifu_fire;
    logic     lsu_fire;
    port_id_e prio;

    // up holds ready low until the first edge after reset release.
    assign rdy_en    = up && !ls;
    assign conflict  = ifu_valid && lsu_valid && (ifu_bank == lsu_bank);
    assign ifu_ready = rdy_en && (!conflict || prio == PORT_IFU);
    assign lsu_ready = rdy_en && (!conflict || prio == PORT_LSU);
    assign ifu_fire  = ifu_valid && ifu_ready;
    assign lsu_fire  = lsu_valid && lsu_ready;

    logic [DW-1:0] bank_dout [NBANK];

    // At most one port hits a bank in any cycle, so LSU wins the mux.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic ifu_hit;
        logic lsu_hit;

        assign ifu_hit = ifu_fire && (ifu_bank == BW'(b));
        assign lsu_hit = lsu_fire && (lsu_bank == BW'(b));

        qpu_itcm_bank #(
            .DW    (DW),
            .MW    (MW),
            .DEPTH (BDP),
            .RW    (RW)
        ) u_bank (
            .clk  (clk),
            .cs   (ifu_hit || lsu_hit),
            .we   (lsu_hit && lsu_we),
            .wem  (lsu_wem),
            .addr (lsu_hit ? lsu_row : ifu_row),
            .din  (lsu_din),
            .dout (bank_dout[b])
        );
    end

    logic          ifu_pend;
    logic          lsu_pend;
    logic          lsu_pwe;
    logic [BW-1:0] ifu_pbank;
    logic [BW-1:0] lsu_pbank;
    logic [DW-1:0] ifu_hold;
    logic [DW-1:0] lsu_hold;
    logic [DW-1:0] ifu_rdata;
    logic [DW-1:0] lsu_rdata;

    assign ifu_rdata = bank_dout[ifu_pbank];
    assign lsu_rdata = bank_dout[lsu_pbank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up        <= 1'b0;
            prio      <= PORT_IFU;
            ifu_pend  <= 1'b0;
            lsu_pend  <= 1'b0;
            lsu_pwe   <= 1'b0;
            ifu_pbank <= '0;
            lsu_pbank <= '0;
            ifu_hold  <= '0;
            lsu_hold  <= '0;
        end else begin
            up       <= 1'b1;
            ifu_pend <= ifu_fire;
            lsu_pend <= lsu_fire;
            if (conflict && rdy_en) begin
                prio <= (prio == PORT_IFU) ? PORT_LSU : PORT_IFU;
            end
            if (ifu_fire) begin
                ifu_pbank <= ifu_bank;
            end
            if (lsu_fire) begin
                lsu_pbank <= lsu_bank;
                lsu_pwe   <= lsu_we;
            end
            if (ifu_pend) begin
                ifu_hold <= ifu_rdata;
            end
            if (lsu_pend && !lsu_pwe) begin
                lsu_hold <= lsu_rdata;
            end
        end
    end

    assign ifu_rsp_valid = ifu_pend;
    assign lsu_rsp_valid = lsu_pend;
    assign ifu_rsp_data  = ifu_pend ? ifu_rdata : ifu_hold;
    assign lsu_rsp_data  = (lsu_pend && !lsu_pwe) ? lsu_rdata : lsu_hold;

endmodule

// File: tb/tb_qpu_itcm_bankram.sv
// Vector-table bench with a reference memory and response scoreboard.
module tb_qpu_itcm_bankram;

    logic        clk;
    logic        rst;
    logic        ifu_valid;
    logic        ifu_ready;
    logic [15:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [63:0] ifu_rsp_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_we;
    logic [15:0] lsu_addr;
    logic [7:0]  lsu_wem;
    logic [63:0] lsu_din;
    logic        lsu_rsp_valid;
    logic [63:0] lsu_rsp_data;
    logic        ls;

    qpu_itcm_bankram dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_valid     (ifu_valid),
        .ifu_ready     (ifu_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_we        (lsu_we),
        .lsu_addr      (lsu_addr),
        .lsu_wem       (lsu_wem),
        .lsu_din       (lsu_din),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .ls            (ls)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        iv;
        logic [15:0] ia;
        logic        lv;
        logic        lw;
        logic [15:0] la;
        logic [7:0]  wem;
        logic [63:0] din;
        logic        lsl;
        logic        er_i;
        logic        er_l;
    } vec_t;

    vec_t        tbl [$];
    logic [63:0] model [int];
    logic [63:0] ifu_q [$];
    logic [63:0] lsu_q [$];
    logic        lsu_st [$];
    logic [63:0] last_ifu;
    logic [63:0] last_lsu;
    int          checks;
    int          errors;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(logic iv, int ia, logic lv, logic lw,
                                int la, logic [7:0] wem, logic [63:0] din,
                                logic lsl, logic er_i, logic er_l);
        vec_t t;
        t.iv = iv; t.ia = 16'(ia); t.lv = lv; t.lw = lw; t.la = 16'(la);
        t.wem = wem; t.din = din; t.lsl = lsl; t.er_i = er_i; t.er_l = er_l;
        return t;
    endfunction

    task automatic run(input vec_t t);
        logic        ri, rl, ai, al, st;
        logic [63:0] e, w;
        @(negedge clk);
        ifu_valid = t.iv; ifu_addr = t.ia;
        lsu_valid = t.lv; lsu_we = t.lw; lsu_addr = t.la;
        lsu_wem = t.wem; lsu_din = t.din; ls = t.lsl;
        #1;
        ri = ifu_ready;
        rl = lsu_ready;
        chk("ifu_ready", 64'(ri), 64'(t.er_i));
        chk("lsu_ready", 64'(rl), 64'(t.er_l));
        ai = t.iv && ri;
        al = t.lv && rl;
        if (ai) ifu_q.push_back(model[int'(t.ia)]);
        if (al) begin
            if (t.lw) begin
                w = model.exists(int'(t.la)) ? model[int'(t.la)] : 64'h0;
                for (int i = 0; i < 8; i++)
                    if (t.wem[i]) w[i*8 +: 8] = t.din[i*8 +: 8];
                model[int'(t.la)] = w;
                lsu_q.push_back(64'h0);
                lsu_st.push_back(1'b1);
            end else begin
                lsu_q.push_back(model[int'(t.la)]);
                lsu_st.push_back(1'b0);
            end
        end
        @(posedge clk);
        #1;
        chk("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(ai));
        if (ai) begin
            e = ifu_q.pop_front();
            chk("ifu_rsp_data", ifu_rsp_data, e);
            last_ifu = e;
        end else begin
            chk("ifu_rsp_hold", ifu_rsp_data, last_ifu);
        end
        chk("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(al));
        if (al) begin
            e = lsu_q.pop_front();
            st = lsu_st.pop_front();
            if (!st) begin
                chk("lsu_rsp_data", lsu_rsp_data, e);
                last_lsu = e;
            end
        end else begin
            chk("lsu_rsp_hold", lsu_rsp_data, last_lsu);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        last_ifu = '0; last_lsu = '0;
        rst = 1'b1; ls = 1'b0;
        ifu_valid = 1'b0; ifu_addr = '0;
        lsu_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0;
        lsu_wem = '0; lsu_din = '0;

        tbl.push_back(mk(0, 0, 1, 1, 4, 8'hFF, 64'h1122334455667788, 0, 1, 1));
        tbl.push_back(mk(1, 4, 0, 0, 0, 8'h00, 64'h0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4, 8'h01, 64'hAA, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 4, 8'h00, 64'h0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 3, 8'hFF, 64'hA5A50303_5A5A0303, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 2, 8'hFF, 64'h02020202_DEADBEEF, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 6, 8'hFF, 64'h06060606_CAFEF00D, 0, 1, 1));
        tbl.push_back(mk(1, 3, 1, 0, 4, 8'h00, 64'h0, 0, 1, 1));
        tbl.push_back(mk(1, 2, 1, 1, 5, 8'hFF, 64'h5555AAAA_5555AAAA, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 5, 8'h00, 64'hFFFFFFFF_FFFFFFFF, 0, 1, 1));
        tbl.push_back(mk(1, 5, 0, 0, 0, 8'h00, 64'h0, 0, 1, 1));
        tbl.push_back(mk(1, 2, 1, 0, 6, 8'h00, 64'h0, 0, 1, 0));
        tbl.push_back(mk(1, 2, 1, 0, 6, 8'h00, 64'h0, 0, 0, 1));
        tbl.push_back(mk(1, 2, 1, 0, 6, 8'h00, 64'h0, 0, 1, 0));
        tbl.push_back(mk(1, 2, 1, 0, 6, 8'h00, 64'h0, 0, 0, 1));
        tbl.push_back(mk(1, 2, 1, 1, 7, 8'hFF, 64'h77777777_12345678, 0, 1, 1));
        tbl.push_back(mk(1, 7, 0, 0, 0, 8'h00, 64'h0, 0, 1, 1));
        tbl.push_back(mk(1, 4, 1, 1, 2, 8'hF0, 64'hFFFFFFFF_00000000, 0, 1, 0));
        tbl.push_back(mk(1, 4, 1, 1, 2, 8'hF0, 64'hFFFFFFFF_00000000, 0, 0, 1));
        tbl.push_back(mk(1, 2, 0, 0, 0, 8'h00, 64'h0, 0, 1, 1));
        tbl.push_back(mk(1, 3, 1, 0, 4, 8'h00, 64'h0, 0, 1, 1));
        tbl.push_back(mk(1, 3, 1, 0, 4, 8'h00, 64'h0, 1, 0, 0));
        tbl.push_back(mk(1, 3, 1, 0, 4, 8'h00, 64'h0, 1, 0, 0));
        tbl.push_back(mk(1, 3, 1, 0, 4, 8'h00, 64'h0, 1, 0, 0));
        tbl.push_back(mk(1, 3, 1, 0, 4, 8'h00, 64'h0, 0, 1, 1));

        #1;
        chk("rst_ifu_ready", 64'(ifu_ready), 64'h0);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'h0);
        chk("rst_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h0);
        chk("rst_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'h0);
        chk("rst_ifu_rsp_data", ifu_rsp_data, 64'h0);
        chk("rst_lsu_rsp_data", lsu_rsp_data, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        lsu_valid = 1'b1;
        #1;
        chk("wake_lsu_ready", 64'(lsu_ready), 64'h0);

        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        @(negedge clk);
        ifu_valid = 1'b1; ifu_addr = 16'd3; lsu_valid = 1'b0; ls = 1'b0;
        #1;
        chk("mid_ifu_ready", 64'(ifu_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("mid_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h1);
        chk("mid_ifu_rsp_data", ifu_rsp_data, model[3]);
        rst = 1'b1;
        #1;
        chk("arst_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h0);
        chk("arst_ifu_ready", 64'(ifu_ready), 64'h0);
        chk("arst_ifu_rsp_data", ifu_rsp_data, 64'h0);
        chk("arst_lsu_rsp_data", lsu_rsp_data, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ifu_ready", 64'(ifu_ready), 64'h0);
        ifu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rel_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h0);
            chk("rel_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'h0);
        end
        last_ifu = '0;
        last_lsu = '0;
        run(mk(1, 2, 1, 0, 6, 8'h00, 64'h0, 0, 1, 0));
        run(mk(1, 2, 1, 0, 6, 8'h00, 64'h0, 0, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
